// File: rtl/display_scan_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : display_scan_if
// Description : Bundle between the display scan controller and its digit mux
//               and display pins.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
interface display_scan_if;
   logic       en_in;
   logic [3:0] digit_in;
   logic [1:0] sel_out;
   logic [6:0] seg_out;
   logic [2:0] an_out;
   logic       slot_tick_out;

   // slave: the scan controller itself
   modport slave (
      input  en_in,
      input  digit_in,
      output sel_out,
      output seg_out,
      output an_out,
      output slot_tick_out
   );

   // master: the surrounding system (mux, display, enable source)
   modport master (
      output en_in,
      output digit_in,
      input  sel_out,
      input  seg_out,
      input  an_out,
      input  slot_tick_out
   );
endinterface
`default_nettype wire

// File: rtl/display_scan.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : display_scan
// Description : 3-digit multiplexed 7-segment scan controller with a guard
//               interval after each digit-select change.
//               Optional macro DISPLAY_SCAN_LEAD_BLANK_EN blanks a zero
//               minutes digit.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module display_scan #(
   parameter int SCAN_DIV = 50000,
   parameter int GUARD    = 2
) (
   input  wire logic     clk_scan,
   input  wire logic     rst_scan,
   display_scan_if.slave scan_if
);

   localparam int c_CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [c_CNT_W-1:0] c_CNT_LAST  = c_CNT_W'(SCAN_DIV - 1);
   localparam logic [c_CNT_W-1:0] c_CNT_LATCH = c_CNT_W'(GUARD - 1);
   localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);

   localparam logic [1:0] c_ST_BLANK = 2'b00;
   localparam logic [1:0] c_ST_SEC   = 2'b01;
   localparam logic [1:0] c_ST_TEN   = 2'b10;
   localparam logic [1:0] c_ST_MIN   = 2'b11;

   localparam logic [6:0] c_SEG_BLANK = 7'b1111111;
   localparam logic [6:0] c_SEG_DASH  = 7'b0111111;

   logic [1:0]         r_state;
   logic [1:0]         w_state_next;
   logic [c_CNT_W-1:0] r_cnt;
   logic [6:0]         r_seg;
   logic [2:0]         r_an;
   logic               r_tick;
   logic [2:0]         w_an_lit;
   logic [6:0]         w_seg_dec;
   logic               w_slot_end;
   logic               w_latch;

   assign w_slot_end = scan_if.en_in && (r_cnt == c_CNT_LAST);
   assign w_latch    = scan_if.en_in && (r_cnt == c_CNT_LATCH);

   // State register; its encoding is also the mux select
   always_ff @(posedge clk_scan) begin
      if (rst_scan) begin
         r_state <= c_ST_BLANK;
      end else if (w_slot_end) begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = c_ST_BLANK;
      case (r_state)
         c_ST_BLANK: w_state_next = c_ST_SEC;
         c_ST_SEC:   w_state_next = c_ST_TEN;
         c_ST_TEN:   w_state_next = c_ST_MIN;
         c_ST_MIN:   w_state_next = c_ST_BLANK;
         default:    w_state_next = c_ST_BLANK;
      endcase
   end

   always_comb begin
      w_an_lit = 3'b111;
      case (r_state)
         c_ST_SEC: w_an_lit = 3'b110;
         c_ST_TEN: w_an_lit = 3'b101;
         c_ST_MIN: w_an_lit = 3'b011;
         default:  w_an_lit = 3'b111;
      endcase

      w_seg_dec = c_SEG_BLANK;
      case (scan_if.digit_in)
         4'h0:    w_seg_dec = 7'b1000000;
         4'h1:    w_seg_dec = 7'b1111001;
         4'h2:    w_seg_dec = 7'b0100100;
         4'h3:    w_seg_dec = 7'b0110000;
         4'h4:    w_seg_dec = 7'b0011001;
         4'h5:    w_seg_dec = 7'b0010010;
         4'h6:    w_seg_dec = 7'b0000010;
         4'h7:    w_seg_dec = 7'b1111000;
         4'h8:    w_seg_dec = 7'b0000000;
         4'h9:    w_seg_dec = 7'b0010000;
         4'hF:    w_seg_dec = c_SEG_BLANK;
         default: w_seg_dec = c_SEG_DASH;
      endcase
`ifdef DISPLAY_SCAN_LEAD_BLANK_EN
      // Leading minutes zero is blanked while its anode is still driven
      if ((r_state == c_ST_MIN) && (scan_if.digit_in == 4'h0)) begin
         w_seg_dec = c_SEG_BLANK;
      end
`endif
   end

   // Slot advance and digit latch are mutually exclusive since SCAN_DIV >= GUARD+2
   always_ff @(posedge clk_scan) begin
      if (rst_scan) begin
         r_cnt  <= '0;
         r_an   <= 3'b111;
         r_seg  <= c_SEG_BLANK;
         r_tick <= 1'b0;
      end else begin
         r_tick <= w_slot_end;
         if (scan_if.en_in) begin
            if (w_slot_end) begin
               r_cnt <= '0;
               r_an  <= 3'b111;
            end else begin
               r_cnt <= r_cnt + c_CNT_ONE;
               if (w_latch) begin
                  r_seg <= w_seg_dec;
                  r_an  <= w_an_lit;
               end
            end
         end
      end
   end

   assign scan_if.sel_out       = r_state;
   assign scan_if.seg_out       = r_seg;
   assign scan_if.an_out        = r_an;
   assign scan_if.slot_tick_out = r_tick;

endmodule
`default_nettype wire

// File: tb/tb_display_scan.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : tb_display_scan
// Description : Scoreboard bench for display_scan with a registered mux model.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_display_scan;

   localparam int SD = 8;
   localparam int GD = 2;
   localparam int N_CYC = 3000;

   typedef struct packed {
      logic [1:0] sel;
      logic [2:0] an;
      logic [6:0] seg;
      logic       tick;
   } exp_t;

   logic   clk_scan = 1'b0;
   logic   rst_scan = 1'b1;
   logic [3:0] val [4];
   exp_t   q [$];
   int     checks = 0;
   int     errors = 0;

   always #5 clk_scan = ~clk_scan;

   display_scan_if ifc ();

   display_scan #(.SCAN_DIV(SD), .GUARD(GD)) dut (
      .clk_scan (clk_scan),
      .rst_scan (rst_scan),
      .scan_if  (ifc)
   );

   // Digit mux with one-cycle register latency
   always @(posedge clk_scan) ifc.digit_in <= val[ifc.sel_out];

   function automatic logic [6:0] seg_of(input int slot, input logic [3:0] d);
      if (d == 4'hF) return 7'b1111111;
      if (d >= 4'hA) return 7'b0111111;
`ifdef DISPLAY_SCAN_LEAD_BLANK_EN
      if (slot == 3 && d == 4'h0) return 7'b1111111;
`endif
      case (d)
         4'h0: return 7'b1000000;
         4'h1: return 7'b1111001;
         4'h2: return 7'b0100100;
         4'h3: return 7'b0110000;
         4'h4: return 7'b0011001;
         4'h5: return 7'b0010010;
         4'h6: return 7'b0000010;
         4'h7: return 7'b1111000;
         4'h8: return 7'b0000000;
         default: return 7'b0010000;
      endcase
   endfunction

   function automatic logic [2:0] an_of(input int slot);
      case (slot)
         1: return 3'b110;
         2: return 3'b101;
         3: return 3'b011;
         default: return 3'b111;
      endcase
   endfunction

   // Stimulus and reference model: n counts enabled cycles since reset
   initial begin
      int n = 0;
      int rnd = 0;
      bit did_min_rst = 0;
      logic [6:0] seg_hold = 7'b1111111;
      logic tick;
      logic rst, en;
      int slot, pos;
      val[0] = 4'hF; val[1] = 4'hF; val[2] = 4'hF; val[3] = 4'hF;
      ifc.en_in = 1'b0;
      for (int cyc = 0; cyc < N_CYC; cyc++) begin
         @(negedge clk_scan);
         rst = (cyc == 0) || ($urandom_range(0, 199) == 0);
         en  = (cyc < 60) ? 1'b1 : ($urandom_range(0, 7) != 0);
         if (!did_min_rst && (n / SD) % 4 == 3 && n % SD == 5) begin
            rst = 1'b1;
            did_min_rst = 1;
         end
         // New digit values only while in the blank slot
         if (!rst && en && (n % (4 * SD)) == 0) begin
            case (rnd)
               0: begin val[1] = 4'd7; val[2] = 4'd4; val[3] = 4'd2; end
               1: begin val[1] = 4'hF; val[2] = 4'd3; val[3] = 4'd9; end
               2: begin val[1] = 4'hC; val[2] = 4'd6; val[3] = 4'd0; end
               3: begin val[1] = 4'd0; val[2] = 4'd7; val[3] = 4'd0; end
               default: begin
                  val[1] = 4'($urandom_range(0, 15));
                  val[2] = 4'($urandom_range(0, 7));
                  val[3] = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
               end
            endcase
            rnd++;
         end
         rst_scan  = rst;
         ifc.en_in = en;

         tick = 1'b0;
         if (rst) begin
            n = 0;
            seg_hold = 7'b1111111;
         end else if (en) begin
            pos = n % SD;
            n++;
            tick = (pos == SD - 1);
            if (pos == GD - 1) begin
               slot = (n / SD) % 4;
               seg_hold = seg_of(slot, (slot == 0) ? 4'hF : val[slot]);
            end
         end
         slot = (n / SD) % 4;
         pos  = n % SD;
         q.push_back('{sel: 2'(slot),
                       an: (pos >= GD) ? an_of(slot) : 3'b111,
                       seg: seg_hold,
                       tick: tick});
      end
      repeat (3) @(negedge clk_scan);
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expected entries never compared, required 0", q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Monitor: compares every post-edge output against the queued expectation
   initial begin
      exp_t e;
      forever begin
         @(posedge clk_scan);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            checks += 4;
            if (ifc.sel_out !== e.sel) begin
               errors++;
               $display("FAIL sel_out t=%0t: got %b, expected %b", $time, ifc.sel_out, e.sel);
            end
            if (ifc.an_out !== e.an) begin
               errors++;
               $display("FAIL an_out t=%0t: got %b, expected %b", $time, ifc.an_out, e.an);
            end
            if (ifc.seg_out !== e.seg) begin
               errors++;
               $display("FAIL seg_out t=%0t: got %b, expected %b", $time, ifc.seg_out, e.seg);
            end
            if (ifc.slot_tick_out !== e.tick) begin
               errors++;
               $display("FAIL slot_tick_out t=%0t: got %b, expected %b", $time, ifc.slot_tick_out, e.tick);
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: doc/display_scan.md
Name: display_scan

Overview:
- Scan controller for the scoreboard's 3-digit multiplexed 7-segment display (minutes, tens-of-seconds, seconds).
- Drives the 2-bit digit select into the digit mux, consumes the mux's registered 4-bit digit, decodes it to segments, and drives the anodes.
- Inserts a guard interval after every select change to absorb the mux's one-cycle register latency and avoid ghosting.

Parameters:
- SCAN_DIV, 50000: clock cycles per scan slot; legal range is GUARD+2 or more.
- GUARD, 2: cycles at the start of each slot with all anodes off; minimum 2.

Ports:
- clk_scan  in  1  system clock
- rst_scan  in  1  synchronous, active-high reset
- en_in  in  1  scan enable; low freezes the block
- digit_in  in  4  registered digit from the mux; 4'hF means null/blank
- sel_out  out  2  digit select to the mux: 01=sec, 10=ten-sec, 11=min, 00=null
- seg_out  out  7  {g,f,e,d,c,b,a}, active-low
- an_out  out  3  active-low anodes: [0]=sec, [1]=ten-sec, [2]=min
- slot_tick_out  out  1  one-cycle pulse on every slot advance

Behaviour:
- Interface: one clock, clk_scan. Reset rst_scan is synchronous and active-high.
- Reset values (all sampled at a clk_scan edge with rst_scan=1): state=BLANK, sel_out=2'b00, cnt=0, an_out=3'b111, seg_out=7'b1111111, slot_tick_out=0. Reset takes priority over en_in.
- Reset mid-slot aborts the slot immediately. The next slot (SEC) starts after SCAN_DIV enabled cycles.
- cnt is a counter running 0..SCAN_DIV-1, advancing only when en_in=1. Width is clog2(SCAN_DIV).
- State cycle: BLANK -> SEC -> TEN -> MIN -> BLANK. Each state's sel_out is 00 / 01 / 10 / 11 respectively. sel_out is registered and equals the state encoding.
- Slot advance happens on an edge with en_in=1 and cnt==SCAN_DIV-1. On that edge:
  - cnt<=0
  - state and sel_out <= next
  - an_out<=3'b111
  - slot_tick_out<=1 for exactly one cycle
- Digit latch happens on an edge with en_in=1 and cnt==GUARD-1. On that edge:
  - seg_out<=decode(digit_in)
  - an_out<=one-hot-low of state (SEC=110, TEN=101, MIN=011, BLANK=111)
- Latency: sel_out changes at edge E0. The mux output is valid after E1. digit_in is captured at edge E(GUARD) or later, so stale data is never displayed.
- Decode table (active-low {g..a}):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - 4'hA..4'hE -> dash 0111111 (error indicator)
  - 4'hF -> blank 1111111
- TEN slot: digit_in arrives as a 3-bit value zero-extended by the mux, so values 6..7 decode normally.
- en_in low: cnt, state, sel_out, seg_out and an_out all hold; slot_tick_out=0.
- Slot advance and digit latch never coincide, because SCAN_DIV >= GUARD+2.
- Guaranteed duty: each digit is lit for SCAN_DIV-GUARD cycles out of every 4*SCAN_DIV.

Optional Feature:
- Macro: DISPLAY_SCAN_LEAD_BLANK_EN.
- Defined: leading-zero blanking. In the MIN slot, digit_in==4'h0 decodes to blank 1111111, and an_out is still driven to 011.
- Undefined: MIN digit 0 shows 1000000, exactly like the other slots. No port or timing difference either way.

Test Plan (SCAN_DIV=8, GUARD=2, mux model with 1-cycle register latency):
1. Reset, then en_in=1: sel_out=00 for 8 cycles, then 01/10/11/00 each for 8 cycles. slot_tick_out pulses every 8 cycles. an_out=111 throughout the BLANK slot.
2. sec=7, ten=4, min=2: in SEC, an_out=111 for cycles 0-1, then 110 with seg_out=1111000 for cycles 2-7. TEN gives 101 with 0011001. MIN gives 011 with 0100100.
3. Mux returns 4'hF or 4'hC in the SEC slot: seg_out=1111111 and 0111111 respectively.
4. Drop en_in for 5 cycles mid-SEC at cnt=4: all outputs hold. After re-enable the slot finishes after 4 more cycles (total 8 enabled).
5. Assert rst_scan at cnt=5 in the MIN slot: the next edge gives an_out=111, seg_out=1111111, sel_out=00, cnt=0, and the sequence restarts as in scenario 1.
6. min=0 with DISPLAY_SCAN_LEAD_BLANK_EN defined: MIN slot gives an_out=011, seg_out=1111111. With the macro undefined: seg_out=1000000.
